cordic_sweep_ctrl: RTL and testbench

Sequencer for the 16-stage CORDIC sine/cosine NCO. It programs the NCO phase increment for a series of tones, sweeping linearly from a start value by a fixed step. For each tone it pulses the NCO start line to clear its phase accumulator and waits out the pipeline fill. It then forwards a fixed number of valid sine/cosine samples tagged with tone index, and reports sweep completion. It sits between the host/config logic and the NCO instance.

---
 rtl/cordic_sweep_ctrl.sv | 149 ++++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sweep_ctrl.sv
// Sweep sequencer for the 16-stage CORDIC NCO.
// Steps tones, waits out the NCO fill and forwards tagged samples.
module cordic_sweep_ctrl #(
  parameter int LAT = 20
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic        Go_i,
  input  logic        Abort_i,
  input  logic [15:0] FreqStart_i,
  input  logic [15:0] FreqStep_i,
  input  logic [7:0]  StepCount_i,
  input  logic [15:0] DwellLen_i,
  input  logic [15:0] Sine_i,
  input  logic [15:0] Cos_i,
  output logic [15:0] NcoAngle_o,
  output logic        NcoStart_o,
  output logic [15:0] Sine_o,
  output logic [15:0] Cos_o,
  output logic        SampleValid_o,
  output logic [7:0]  ToneIdx_o,
  output logic        LastSample_o,
  output logic        Busy_o,
  output logic        Done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RESTART,
    FILL,
    RUN
  } state_t;

  localparam logic [15:0] FILL_END = 16'(LAT - 1);

  state_t      state;
  logic [15:0] angle;
  logic [15:0] step;
  logic [15:0] dwell_end;
  logic [15:0] cnt;
  logic [7:0]  tone;
  logic [7:0]  last_tone;
  logic [7:0]  run_tone;
  logic        run_q;
  logic        run_last;
  logic        in_flight;
  logic        kill;
  logic        accept;

  // Busy_o covers the trailing capture cycle after the FSM has
  // returned to IDLE, so it also gates Go/Abort there.
  assign in_flight = (state != IDLE) || Busy_o;
  assign kill      = Abort_i && in_flight;
  assign accept    = Go_i && !Abort_i && !in_flight;

  // Sweep FSM with registered NCO controls and a one-deep capture stage.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state         <= IDLE;
      angle         <= '0;
      step          <= '0;
      dwell_end     <= '0;
      cnt           <= '0;
      tone          <= '0;
      last_tone     <= '0;
      run_tone      <= '0;
      run_q         <= 1'b0;
      run_last      <= 1'b0;
      NcoAngle_o    <= '0;
      NcoStart_o    <= 1'b1;
      Sine_o        <= '0;
      Cos_o         <= '0;
      SampleValid_o <= 1'b0;
      ToneIdx_o     <= '0;
      LastSample_o  <= 1'b0;
      Busy_o        <= 1'b0;
      Done_o        <= 1'b0;
    end else begin
      Busy_o        <= (state != IDLE);
      SampleValid_o <= run_q && !kill;
      LastSample_o  <= run_q && run_last && !kill;
      Done_o        <= run_q && run_last && !kill;
      if (run_q && !kill) begin
        Sine_o    <= Sine_i;
        Cos_o     <= Cos_i;
        ToneIdx_o <= run_tone;
      end
      run_q    <= 1'b0;
      run_last <= 1'b0;

      unique case (state)
        IDLE: begin
          NcoStart_o <= 1'b1;
          if (accept) begin
            step      <= FreqStep_i;
            last_tone <= StepCount_i;
            dwell_end <= (DwellLen_i == 16'd0) ? 16'd0
                                               : DwellLen_i - 16'd1;
            tone      <= '0;
            angle     <= FreqStart_i;
            state     <= RESTART;
          end
        end
        RESTART: begin
          NcoStart_o <= 1'b1;
          NcoAngle_o <= angle;
          cnt        <= '0;
          state      <= FILL;
        end
        FILL: begin
          NcoStart_o <= 1'b0;
          if (cnt == FILL_END) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RUN: begin
          NcoStart_o <= 1'b0;
          run_q      <= 1'b1;
          run_tone   <= tone;
          if (cnt == dwell_end) begin
            cnt <= '0;
            if (tone == last_tone) begin
              run_last <= 1'b1;
              state    <= IDLE;
            end else begin
              tone  <= tone + 8'd1;
              angle <= angle + step;
              state <= RESTART;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase

      if (kill) begin
        state      <= IDLE;
        NcoStart_o <= 1'b1;
        Busy_o     <= 1'b0;
        run_q      <= 1'b0;
        run_last   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Bench for cordic_sweep_ctrl: schedule model plus directed sweeps.
// Cycle n below means the outputs seen after rising edge n.
module tb_cordic_sweep_ctrl;

  localparam int LAT = 20;
  localparam int INF = 2147483647;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        abort;
  logic [15:0] fstart;
  logic [15:0] fstep;
  logic [7:0]  scnt;
  logic [15:0] dwell;
  logic [15:0] sine_i;
  logic [15:0] cos_i;
  logic [15:0] angle_o;
  logic        start_o;
  logic [15:0] sine_o;
  logic [15:0] cos_o;
  logic        valid_o;
  logic [7:0]  tone_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  cordic_sweep_ctrl #(.LAT(LAT)) dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .Go_i         (go),
    .Abort_i      (abort),
    .FreqStart_i  (fstart),
    .FreqStep_i   (fstep),
    .StepCount_i  (scnt),
    .DwellLen_i   (dwell),
    .Sine_i       (sine_i),
    .Cos_i        (cos_i),
    .NcoAngle_o   (angle_o),
    .NcoStart_o   (start_o),
    .Sine_o       (sine_o),
    .Cos_o        (cos_o),
    .SampleValid_o(valid_o),
    .ToneIdx_o    (tone_o),
    .LastSample_o (last_o),
    .Busy_o       (busy_o),
    .Done_o       (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fs(input int c);
    return 16'(c * 37 + 4660);
  endfunction

  function automatic logic [15:0] fc(input int c);
    return 16'((c * 91) ^ 23130);
  endfunction

  // NCO stand-in: a distinct sample every cycle
  assign sine_i = fs(cyc);
  assign cos_i  = fc(cyc);

  logic        rst_q;
  logic        go_q;
  logic        ab_q;
  logic [15:0] fs_q;
  logic [15:0] st_q;
  logic [7:0]  sc_q;
  logic [15:0] dw_q;

  always @(posedge clk) begin
    rst_q <= rst;
    go_q  <= go;
    ab_q  <= abort;
    fs_q  <= fstart;
    st_q  <= fstep;
    sc_q  <= scnt;
    dw_q  <= dwell;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  bit          started = 0;
  bit          have = 0;
  int          e_go = 0;
  int          endc = INF;
  int          m_n = 1;
  int          m_d = 1;
  int          m_p = 1;
  logic [15:0] m_start = '0;
  logic [15:0] m_step = '0;
  logic [15:0] idle_angle = '0;
  logic [15:0] end_angle = '0;
  logic [15:0] cur_angle = '0;
  logic [15:0] hs = '0;
  logic [15:0] hc = '0;
  logic [7:0]  ht = '0;
  int          vcount = 0;
  int          dcount = 0;

  // Angle programmed by cycle t of the current sweep
  function automatic logic [15:0] ang(input int t);
    int k;
    if (t < 1) return idle_angle;
    k = (t - 1) / m_p;
    if (k > m_n - 1) k = m_n - 1;
    return 16'(int'(m_start) + int'(m_step) * k);
  endfunction

  // Model of the tone schedule, checked every cycle
  always @(negedge clk) begin : cmp
    int n;
    int t;
    int tp;
    int v;
    int kv;
    int rv;
    bit inflight;
    logic e_ns;
    logic e_busy;
    logic e_valid;
    logic e_last;
    logic e_done;
    logic [15:0] e_ang;
    n = cyc;
    e_ns = 1'b1;
    e_busy = 1'b0;
    e_valid = 1'b0;
    e_last = 1'b0;
    e_done = 1'b0;
    e_ang = cur_angle;
    if (rst_q === 1'b1) begin
      started = 1;
      have = 0;
      idle_angle = '0;
      cur_angle = '0;
      e_ang = '0;
      hs = '0;
      hc = '0;
      ht = '0;
    end else if (started) begin
      tp = n - 1 - e_go;
      inflight = have && (n - 1 < endc) && tp >= 0 && tp <= m_n * m_p;
      if (ab_q && inflight) begin
        endc = n;
        end_angle = ang(n - e_go);
      end else if (go_q && !ab_q && !inflight) begin
        idle_angle = cur_angle;
        have = 1;
        e_go = n;
        endc = INF;
        m_start = fs_q;
        m_step = st_q;
        m_n = int'(sc_q) + 1;
        m_d = (dw_q == 16'd0) ? 1 : int'(dw_q);
        m_p = LAT + 1 + m_d;
      end
      if (have && n >= endc) begin
        e_ang = end_angle;
      end else if (have) begin
        t = n - e_go;
        e_ang = ang(t);
        if (t >= 1) begin
          e_ns = ((t - 1) % m_p == 0) || (t - 1 >= m_n * m_p);
          e_busy = (t <= m_n * m_p);
        end
        v = t - 3 - LAT;
        if (v >= 0) begin
          kv = v / m_p;
          rv = v % m_p;
          e_valid = (kv < m_n) && (rv < m_d);
          e_last = e_valid && kv == m_n - 1 && rv == m_d - 1;
          if (e_valid) begin
            hs = fs(n - 1);
            hc = fc(n - 1);
            ht = 8'(kv);
          end
        end
        e_done = (t == 1 + m_n * m_p);
      end
    end
    if (started) begin
      chk("nco_start", start_o, e_ns);
      chk("nco_angle", angle_o, e_ang);
      chk("busy", busy_o, e_busy);
      chk("valid", valid_o, e_valid);
      chk("last", last_o, e_last);
      chk("done", done_o, e_done);
      chk("sine", sine_o, hs);
      chk("cos", cos_o, hc);
      chk("tone", tone_o, ht);
      cur_angle = e_ang;
      if (valid_o === 1'b1) vcount++;
      if (done_o === 1'b1) dcount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic go_sweep(input logic [15:0] s, input logic [15:0] st,
                          input logic [7:0] c, input logic [15:0] d,
                          output int e);
    fstart = s;
    fstep = st;
    scnt = c;
    dwell = d;
    go = 1'b1;
    tick();
    e = cyc;
    go = 1'b0;
    fstart = 16'($urandom);
    fstep = 16'($urandom);
    scnt = 8'($urandom);
    dwell = 16'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int v0;
    int d0;
    rst = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    fstart = '0;
    fstep = '0;
    scnt = '0;
    dwell = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_start", start_o, 1);
    chk("rst_angle", angle_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_sine", sine_o, 0);

    // single tone, with Go pulses that must be ignored
    go_sweep(16'h0100, 16'h1111, 8'd0, 16'd4, e);
    until_cyc(e + 1);
    chk("t1_start1", start_o, 1);
    chk("t1_angle", angle_o, 16'h0100);
    chk("t1_busy", busy_o, 1);
    until_cyc(e + 2);
    chk("t1_start2", start_o, 0);
    until_cyc(e + 9);
    go = 1'b1;
    fstart = 16'hdead;
    tick();
    go = 1'b0;
    until_cyc(e + 22);
    chk("t1_valid22", valid_o, 0);
    until_cyc(e + 23);
    chk("t1_valid23", valid_o, 1);
    chk("t1_sine23", sine_o, fs(e + 22));
    until_cyc(e + 25);
    chk("t1_start25", start_o, 0);
    chk("t1_done25", done_o, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("t1_done26", done_o, 1);
    chk("t1_last26", last_o, 1);
    chk("t1_start26", start_o, 1);
    chk("t1_busy26", busy_o, 0);
    repeat (3) tick();
    chk("t1_idle", busy_o, 0);

    // three tones wrapping through zero
    v0 = vcount;
    go_sweep(16'hff00, 16'h0080, 8'd2, 16'd2, e);
    until_cyc(e + 1);
    chk("w_ang0", angle_o, 16'hff00);
    until_cyc(e + 23);
    chk("w_ang0h", angle_o, 16'hff00);
    until_cyc(e + 24);
    chk("w_ang1", angle_o, 16'hff80);
    until_cyc(e + 47);
    chk("w_ang2", angle_o, 16'h0000);
    until_cyc(e + 69);
    chk("w_done69", done_o, 0);
    until_cyc(e + 70);
    chk("w_done70", done_o, 1);
    tick();
    chk("w_samples", vcount - v0, 6);

    // abort in the fill of tone 1
    v0 = vcount;
    d0 = dcount;
    go_sweep(16'h1000, 16'h0010, 8'd3, 16'd3, e);
    until_cyc(e + 29);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_start", start_o, 1);
    chk("ab_busy", busy_o, 0);
    until_cyc(e + 130);
    chk("ab_samples", vcount - v0, 3);
    chk("ab_nodone", dcount - d0, 0);

    // zero dwell acts as one sample
    v0 = vcount;
    go_sweep(16'h4000, 16'h0000, 8'd0, 16'd0, e);
    until_cyc(e + 1);
    chk("d0_busy", busy_o, 1);
    until_cyc(e + 22);
    chk("d0_done22", done_o, 0);
    until_cyc(e + 23);
    chk("d0_done23", done_o, 1);
    chk("d0_valid23", valid_o, 1);
    until_cyc(e + 30);
    chk("d0_samples", vcount - v0, 1);

    // Go with Abort in idle
    go = 1'b1;
    abort = 1'b1;
    tick();
    go = 1'b0;
    abort = 1'b0;
    chk("ga_busy1", busy_o, 0);
    tick();
    chk("ga_busy2", busy_o, 0);
    chk("ga_start", start_o, 1);

    // reset in the middle of RUN
    go_sweep(16'h2000, 16'h0100, 8'd1, 16'd8, e);
    until_cyc(e + 24);
    chk("r_valid", valid_o, 1);
    rst = 1'b1;
    tick();
    chk("r_start", start_o, 1);
    chk("r_angle", angle_o, 0);
    chk("r_sine", sine_o, 0);
    chk("r_cos", cos_o, 0);
    chk("r_tone", tone_o, 0);
    chk("r_valid0", valid_o, 0);
    chk("r_busy", busy_o, 0);
    tick();
    rst = 1'b0;
    v0 = vcount;
    until_cyc(e + 60);
    chk("r_nosamp", vcount - v0, 0);
    chk("r_idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
